// File: rtl/cva6_clic_arb_pkg.sv
// Shared types for the CLIC sequential arbiter: FSM state, scan candidate and the
// candidate ordering (higher level first, equal level -> higher id).
package cva6_clic_arb_pkg;

  localparam int unsigned ArbIdWidth    = 8;
  localparam int unsigned ArbLevelWidth = 8;

  typedef enum logic {
    SCAN,
    PRESENT
  } arb_state_e;

  typedef struct packed {
    logic                     valid;
    logic [ArbIdWidth-1:0]    id;
    logic [ArbLevelWidth-1:0] level;
    logic                     shv;
  } cand_t;

  // True when a should replace b: an invalid a never wins, any valid a beats an invalid b.
  function automatic logic cand_better(input cand_t a, input cand_t b);
    return a.valid && (!b.valid || (a.level > b.level) ||
                       ((a.level == b.level) && (a.id > b.id)));
  endfunction

endpackage

// File: rtl/cva6_clic_arb_group_max.sv
// Combinational max over one scan group: picks the pending+enabled source with the
// highest non-zero level, ties resolved toward the higher id.
module cva6_clic_arb_group_max
  import cva6_clic_arb_pkg::*;
#(
  parameter int unsigned GroupSize = 32
) (
  input  logic [GroupSize-1:0]               ip,
  input  logic [GroupSize-1:0]               ie,
  input  logic [GroupSize*ArbLevelWidth-1:0] level,
  input  logic [GroupSize-1:0]               shv,
  input  logic [ArbIdWidth-1:0]              id_base,
  output cand_t                              best
);

  cand_t cand;

  always_comb begin
    best = '0;
    cand = '0;
    for (int i = 0; i < GroupSize; i++) begin
      cand.level = level[i*ArbLevelWidth +: ArbLevelWidth];
      cand.valid = ip[i] && ie[i] && (cand.level != '0);
      cand.id    = id_base + ArbIdWidth'(i);
      cand.shv   = shv[i];
      if (cand_better(cand, best)) begin
        best = cand;
      end
    end
  end

endmodule

// File: rtl/cva6_clic_irq_arbiter.sv
// Sequential CLIC arbiter: scans GroupSize sources per cycle, qualifies the pass winner
// against max(mintthresh, mil) and presents it to the core. Option: CLIC_ARB_SHV_EN.
module cva6_clic_irq_arbiter
  import cva6_clic_arb_pkg::*;
#(
  parameter int unsigned NumSrc     = 256,
  parameter int unsigned GroupSize  = 32,
  parameter int unsigned LevelWidth = ArbLevelWidth,
  localparam int unsigned IdWidth   = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumSrc-1:0]            ip_i,
  input  logic [NumSrc-1:0]            ie_i,
  input  logic [NumSrc*LevelWidth-1:0] level_i,
  input  logic [NumSrc-1:0]            shv_i,
  input  logic [LevelWidth-1:0]        mintthresh_i,
  input  logic [LevelWidth-1:0]        mil_i,
  output logic                         irq_valid_o,
  output logic [IdWidth-1:0]           irq_id_o,
  output logic [LevelWidth-1:0]        irq_level_o,
  output logic                         irq_shv_o,
  input  logic                         irq_ready_i,
  output logic                         claim_o,
  output logic [IdWidth-1:0]           claim_id_o
);

  localparam int unsigned NumGroups = NumSrc / GroupSize;
  localparam int unsigned GrpWidth  = $clog2(NumGroups);
  localparam int unsigned GsWidth   = $clog2(GroupSize);

  arb_state_e            state;
  logic [GrpWidth-1:0]   grp_cnt;
  cand_t                 best;
  cand_t                 grp_cand;
  cand_t                 merged;
  logic [IdWidth-1:0]    id_base;
  logic [GroupSize-1:0]  grp_shv;
  logic [LevelWidth-1:0] thresh;
  logic                  last_grp;
  logic                  qualify;
  logic                  withdraw;

  assign id_base  = {grp_cnt, {GsWidth{1'b0}}};
  assign thresh   = (mintthresh_i > mil_i) ? mintthresh_i : mil_i;
  assign last_grp = (grp_cnt == GrpWidth'(NumGroups - 1));
  assign merged   = cand_better(grp_cand, best) ? grp_cand : best;
  assign qualify  = merged.valid && (merged.level > thresh);
  assign withdraw = !ip_i[irq_id_o] || !ie_i[irq_id_o] || (irq_level_o <= thresh);

`ifdef CLIC_ARB_SHV_EN
  logic shv_reg;
  assign grp_shv   = shv_i[id_base +: GroupSize];
  assign irq_shv_o = shv_reg;
`else
  logic unused_shv;
  assign unused_shv = ^shv_i;
  assign grp_shv    = '0;
  assign irq_shv_o  = 1'b0;
`endif

  cva6_clic_arb_group_max #(
    .GroupSize(GroupSize)
  ) u_group_max (
    .ip      (ip_i[id_base +: GroupSize]),
    .ie      (ie_i[id_base +: GroupSize]),
    .level   (level_i[int'(id_base)*LevelWidth +: GroupSize*LevelWidth]),
    .shv     (grp_shv),
    .id_base (id_base),
    .best    (grp_cand)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= SCAN;
      grp_cnt     <= '0;
      best        <= '0;
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
      irq_level_o <= '0;
      claim_o     <= 1'b0;
      claim_id_o  <= '0;
`ifdef CLIC_ARB_SHV_EN
      shv_reg     <= 1'b0;
`endif
    end else begin
      claim_o <= 1'b0;
      case (state)
        SCAN: begin
          if (last_grp) begin
            grp_cnt <= '0;
            best    <= '0;
            if (qualify) begin
              irq_valid_o <= 1'b1;
              irq_id_o    <= merged.id;
              irq_level_o <= merged.level;
`ifdef CLIC_ARB_SHV_EN
              shv_reg     <= merged.shv;
`endif
              state       <= PRESENT;
            end
          end else begin
            grp_cnt <= grp_cnt + 1'b1;
            best    <= merged;
          end
        end
        PRESENT: begin
          // Acceptance takes priority over a simultaneous withdraw condition.
          if (irq_ready_i) begin
            claim_o     <= 1'b1;
            claim_id_o  <= irq_id_o;
            irq_valid_o <= 1'b0;
            grp_cnt     <= '0;
            best        <= '0;
            state       <= SCAN;
          end else if (withdraw) begin
            irq_valid_o <= 1'b0;
            grp_cnt     <= '0;
            best        <= '0;
            state       <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_cva6_clic_irq_arbiter.sv
// Self-checking bench for cva6_clic_irq_arbiter (256 sources, 8 groups of 32):
// directed vector table plus hand-written claim/withdraw/reset sequences.
module tb_cva6_clic_irq_arbiter;

  logic           clk = 1'b0;
  logic           rst;
  logic [255:0]   ip, ie, shv;
  logic [2047:0]  level;
  logic [7:0]     mintthresh, mil;
  logic           irq_valid, irq_shv, irq_ready, claim;
  logic [7:0]     irq_id, irq_level, claim_id;

  int checks = 0;
  int errors = 0;

`ifdef CLIC_ARB_SHV_EN
  localparam logic EXP_SHV = 1'b1;
`else
  localparam logic EXP_SHV = 1'b0;
`endif

  always #5 clk = ~clk;

  cva6_clic_irq_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ip_i         (ip),
    .ie_i         (ie),
    .level_i      (level),
    .shv_i        (shv),
    .mintthresh_i (mintthresh),
    .mil_i        (mil),
    .irq_valid_o  (irq_valid),
    .irq_id_o     (irq_id),
    .irq_level_o  (irq_level),
    .irq_shv_o    (irq_shv),
    .irq_ready_i  (irq_ready),
    .claim_o      (claim),
    .claim_id_o   (claim_id)
  );

  typedef struct {
    int       a_id;
    bit [7:0] a_lvl;
    int       b_id;
    bit [7:0] b_lvl;
    bit       b_ip;
    bit       b_ie;
    bit [7:0] thr;
    bit [7:0] ml;
    bit       exp_valid;
    bit [7:0] exp_id;
    bit [7:0] exp_lvl;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ip = '0; ie = '0; shv = '0; level = '0;
    mintthresh = '0; mil = '0; irq_ready = 1'b0;
  endtask

  task automatic set_src(input int id, input logic [7:0] lvl, input logic p, input logic e,
                         input logic s);
    ip[id] = p; ie[id] = e; shv[id] = s;
    level[id*8 +: 8] = lvl;
  endtask

  // Hold reset while inputs are loaded; the pass starts at the first posedge after release.
  task automatic reset_align();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, irq_valid, 0);
    check({tag, "_id"}, irq_id, 0);
    check({tag, "_level"}, irq_level, 0);
    check({tag, "_shv"}, irq_shv, 0);
    check({tag, "_claim"}, claim, 0);
    check({tag, "_claim_id"}, claim_id, 0);
  endtask

  // Bounded wait for irq_valid, sampled on negedges.
  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (irq_valid) seen = 1'b1;
    end
  endtask

  task automatic present(input string tag, input int id, input logic [7:0] lvl);
    bit seen;
    clear_inputs();
    set_src(id, lvl, 1'b1, 1'b1, 1'b0);
    reset_align();
    wait_valid(20, seen);
    check({tag, "_present_valid"}, seen, 1);
    check({tag, "_present_id"}, irq_id, id);
  endtask

  vec_t vecs[9];

  initial begin
    bit seen;
    bit ok;
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{5,   8'h40, 0,   8'h00, 0, 0, 8'h00, 8'h00, 1, 5,   8'h40};
    vecs[1] = '{10,  8'h80, 200, 8'h80, 1, 1, 8'h00, 8'h00, 1, 200, 8'h80};
    vecs[2] = '{7,   8'h30, 0,   8'h00, 0, 0, 8'h30, 8'h00, 0, 0,   8'h00};
    vecs[3] = '{7,   8'h30, 0,   8'h00, 0, 0, 8'h2F, 8'h00, 1, 7,   8'h30};
    vecs[4] = '{7,   8'h30, 0,   8'h00, 0, 0, 8'h00, 8'h30, 0, 0,   8'h00};
    vecs[5] = '{3,   8'h00, 0,   8'h00, 0, 0, 8'h00, 8'h00, 0, 0,   8'h00};
    vecs[6] = '{255, 8'h01, 0,   8'h02, 1, 1, 8'h00, 8'h00, 1, 0,   8'h02};
    vecs[7] = '{31,  8'h10, 32,  8'h10, 1, 1, 8'h00, 8'h00, 1, 32,  8'h10};
    vecs[8] = '{4,   8'h10, 100, 8'h90, 1, 0, 8'h00, 8'h00, 1, 4,   8'h10};

    #12;
    check_outputs_zero("reset");

    // Vector table: exactly NumGroups=8 cycles from pass start to irq_valid.
    for (int v = 0; v < 9; v++) begin
      clear_inputs();
      set_src(vecs[v].a_id, vecs[v].a_lvl, 1'b1, 1'b1, 1'b0);
      if (vecs[v].b_ip || vecs[v].b_ie)
        set_src(vecs[v].b_id, vecs[v].b_lvl, vecs[v].b_ip, vecs[v].b_ie, 1'b0);
      mintthresh = vecs[v].thr;
      mil = vecs[v].ml;
      reset_align();
      repeat (7) @(negedge clk);
      check($sformatf("vec%0d_early_valid", v), irq_valid, 0);
      @(negedge clk);
      ok = (irq_valid === vecs[v].exp_valid);
      check($sformatf("vec%0d_valid", v), irq_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_id", v), irq_id, vecs[v].exp_id);
        check($sformatf("vec%0d_level", v), irq_level, vecs[v].exp_lvl);
      end
      $display("vec %0d: valid=%0d id=%0d level=%0h", v, irq_valid, irq_id, irq_level);
    end

    // Accept: claim pulse carries the id, lasts one cycle.
    present("claim", 5, 8'h40);
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    check("claim_pulse", claim, 1);
    check("claim_id", claim_id, 5);
    check("claim_valid_drop", irq_valid, 0);
    @(negedge clk);
    check("claim_single_cycle", claim, 0);
    $display("claim: id=%0d", claim_id);

    // Threshold blocks src 7 until lowered; then it appears within two passes.
    clear_inputs();
    set_src(7, 8'h30, 1'b1, 1'b1, 1'b0);
    mintthresh = 8'h30;
    reset_align();
    wait_valid(20, seen);
    check("thresh_blocked", seen, 0);
    repeat (3) @(negedge clk);
    mintthresh = 8'h2F;
    wait_valid(17, seen);
    check("thresh_lowered_valid", seen, 1);
    check("thresh_lowered_id", irq_id, 7);
    $display("thresh: valid=%0d id=%0d", irq_valid, irq_id);

    // Withdraw on ie drop: held stable, then valid falls next cycle without a claim.
    present("wd", 3, 8'h20);
    set_src(50, 8'h90, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("no_preempt_valid", irq_valid, 1);
    check("no_preempt_id", irq_id, 3);
    check("no_preempt_level", irq_level, 8'h20);
    ie[3] = 1'b0;
    @(negedge clk);
    check("wd_valid_drop", irq_valid, 0);
    check("wd_no_claim", claim, 0);
    @(negedge clk);
    check("wd_no_claim_later", claim, 0);
    $display("withdraw: valid=%0d claim=%0d", irq_valid, claim);

    // Ready and withdraw in the same cycle: accept wins.
    present("rw", 3, 8'h20);
    ip[3] = 1'b0;
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    check("rw_claim", claim, 1);
    check("rw_claim_id", claim_id, 3);
    $display("ready+withdraw: claim=%0d id=%0d", claim, claim_id);

    // SHV bit follows the winner only when the option is built in.
    clear_inputs();
    set_src(9, 8'h55, 1'b1, 1'b1, 1'b1);
    reset_align();
    wait_valid(20, seen);
    check("shv_valid", seen, 1);
    check("shv_id", irq_id, 9);
    check("shv_bit", irq_shv, EXP_SHV);
    $display("shv: id=%0d shv=%0d", irq_id, irq_shv);

    // Asynchronous reset mid-scan, then while presenting with ready asserted.
    clear_inputs();
    set_src(5, 8'h40, 1'b1, 1'b1, 1'b1);
    reset_align();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_midscan");
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_restart_early", irq_valid, 0);
    @(negedge clk);
    check("rst_restart_valid", irq_valid, 1);
    check("rst_restart_id", irq_id, 5);
    irq_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_present");
    @(negedge clk);
    check("rst_claim_dropped", claim, 0);
    irq_ready = 1'b0;
    rst = 1'b0;
    $display("reset: valid=%0d claim=%0d", irq_valid, claim);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
